// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encodings, line levels and default bit timing.
// Used by both the receiver and the transmitter so their state encodings stay aligned.
package uart_pkg;

    localparam int c_DATA_W             = 8;
    localparam int c_CYCLES_PER_BIT_DEF = 217;

    localparam logic c_LOW  = 1'b0;
    localparam logic c_HIGH = 1'b1;

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_START   = 5'b00010,
        S_DATA    = 5'b00100,
        S_STOP    = 5'b01000,
        S_CLEANUP = 5'b10000
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin.
// The flops reset to the idle line level so reset release never looks like a start bit.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter logic p_RESET_VAL = c_HIGH
) (
    input  logic i_CLK,
    input  logic i_RESET_n,
    input  logic i_ASYNC,
    output logic o_SYNC
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_meta <= p_RESET_VAL;
            r_sync <= p_RESET_VAL;
        end else begin
            r_meta <= i_ASYNC;
            r_sync <= r_meta;
        end
    end

    assign o_SYNC = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with start-glitch rejection and framing-error flag.
// o_STATE_DBG exposes the one-hot FSM state for observation.
module uart_rx
    import uart_pkg::*;
#(
    parameter int c_CYCLES_PER_BIT = c_CYCLES_PER_BIT_DEF
) (
    input  logic                i_CLK,
    input  logic                i_RESET_n,
    input  logic                i_SERIAL_DATA,
    output logic [c_DATA_W-1:0] o_PARALLEL_DATA,
    output logic                o_RX_DV,
    output logic                o_RX_ACTIVE,
    output logic                o_FRAME_ERR,
    output logic [4:0]          o_STATE_DBG
);

    localparam int                 c_CNT_W = $clog2(c_CYCLES_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF  = c_CNT_W'((c_CYCLES_PER_BIT - 1) / 2);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_CYCLES_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic w_rx_s;

    uart_rx_sync #(
        .p_RESET_VAL (c_HIGH)
    ) u_sync (
        .i_CLK     (i_CLK),
        .i_RESET_n (i_RESET_n),
        .i_ASYNC   (i_SERIAL_DATA),
        .o_SYNC    (w_rx_s)
    );

    uart_state_t         r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2:0]          r_idx;
    logic [c_DATA_W-1:0] r_shift;
    logic [c_DATA_W-1:0] r_data;
    logic                r_rx_dv;
    logic                r_rx_active;
    logic                r_frame_err;

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_rx_dv     <= 1'b0;
            r_rx_active <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted below.
            r_rx_dv     <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt       <= '0;
                    r_idx       <= '0;
                    r_rx_active <= 1'b0;
                    if (w_rx_s == c_LOW) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    // Re-check the line at mid start bit; a high here was only a glitch.
                    if (r_cnt == c_HALF) begin
                        r_cnt <= '0;
                        if (w_rx_s == c_LOW) begin
                            r_rx_active <= 1'b1;
                            r_state     <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == 3'd7) begin
                            r_idx   <= '0;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s == c_HIGH) begin
                            r_data  <= r_shift;
                            r_rx_dv <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= S_CLEANUP;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end

                S_CLEANUP: begin
                    // Leaving on the first high sample (mid stop bit) lets a back-to-back start bit be caught.
                    if (w_rx_s == c_HIGH) begin
                        r_rx_active <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_cnt       <= '0;
                    r_idx       <= '0;
                    r_rx_active <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_PARALLEL_DATA = r_data;
    assign o_RX_DV         = r_rx_dv;
    assign o_RX_ACTIVE     = r_rx_active;
    assign o_FRAME_ERR     = r_frame_err;
    assign o_STATE_DBG     = r_state;

endmodule
